// File: rtl/apg_sample_feeder.sv
// -----------------------------------------------------------------------------
// apg_sample_feeder
//
// Unpacks 32-bit words of packed samples and feeds them, one sample at a time,
// into a pattern-generator write buffer. Each word holds 32/NUM_SIG lanes, and
// lane 0 is emitted first. A transfer emits exactly n_samples_target samples.
// Strobes are never issued on two consecutive cycles. Emission stalls whenever
// the downstream buffer occupancy reaches BUF_DEPTH.
//
// State flow: IDLE/DONE --start--> LOAD --word--> EMIT --last lane--> LOAD
//             EMIT --target reached--> DONE ; any state --abort--> IDLE
//
// Parameters
//   NUM_SIG    sample width in bits (32/NUM_SIG lanes per word)
//   BUF_DEPTH  downstream occupancy at or above which emission stalls
//
// Ports
//   axi_clk                 clock, rising edge
//   axi_resetn              asynchronous active-low reset
//   start                   one-cycle pulse, begins a transfer from IDLE/DONE
//   abort                   cancels the transfer, returns to IDLE
//   n_samples_target[31:0]  samples to emit, captured on an accepted start
//   s_data[31:0]            packed sample word
//   s_valid / s_ready       word handshake (s_ready is high only in LOAD)
//   write_buffer_len[31:0]  current downstream buffer occupancy
//   write_channel           registered sample presented downstream
//   write_channel_wrStrobe  one-cycle write strobe for write_channel
//   busy                    high in LOAD or EMIT
//   done                    high in DONE
//   samples_sent[31:0]      strobes issued in the current transfer
//   overrun                 only when APG_FEEDER_OVERRUN_CHECK_EN is defined:
//                           sticky flag for a strobe into a full buffer or an
//                           occupancy above BUF_DEPTH; cleared by reset/start
// -----------------------------------------------------------------------------
module apg_sample_feeder #(
  parameter int NUM_SIG   = 8,
  parameter int BUF_DEPTH = 16
) (
  input  logic               axi_clk,
  input  logic               axi_resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        n_samples_target,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        write_buffer_len,
  output logic [NUM_SIG-1:0] write_channel,
  output logic               write_channel_wrStrobe,
  output logic               busy,
  output logic               done,
  output logic [31:0]        samples_sent
`ifdef APG_FEEDER_OVERRUN_CHECK_EN
  ,output logic              overrun
`endif
);

  localparam int LANES  = 32 / NUM_SIG;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [31:0]       DEPTH     = 32'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [31:0]         target_q;
  logic [31:0]         word_q;
  logic [LANE_W-1:0]   lane_q;
  logic [NUM_SIG-1:0]  lane_data;

  logic                room;
  logic                start_ok;
  logic                accept;
  logic                fire;
  logic [31:0]         sent_inc;
  logic                reached;
  logic                last_lane;

  // Status outputs decode directly from the state register, so reset forces
  // them low through the state itself.
  assign s_ready = (state == S_LOAD);
  assign busy    = (state == S_LOAD) || (state == S_EMIT);
  assign done    = (state == S_DONE);

  assign room      = (write_buffer_len < DEPTH);
  assign sent_inc  = samples_sent + 32'd1;
  assign reached   = (sent_inc == target_q);
  assign last_lane = (lane_q == LAST_LANE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode. Abort overrides everything, including a
  // start or an emission in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next = state;
    start_ok   = 1'b0;
    accept     = 1'b0;
    fire       = 1'b0;

    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            start_ok   = 1'b1;
            state_next = (n_samples_target == 32'd0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            accept     = 1'b1;
            state_next = S_EMIT;
          end
        end
        S_EMIT: begin
          // The registered strobe doubles as the "strobed last cycle" flag,
          // which spaces strobes at least one idle cycle apart.
          if (room && !write_channel_wrStrobe) begin
            fire = 1'b1;
            if (reached) begin
              // Remaining lanes of the current word are dropped.
              state_next = S_DONE;
            end else if (last_lane) begin
              state_next = S_LOAD;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lane select: pick the NUM_SIG-bit slice addressed by the lane index.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_data = word_q[i*NUM_SIG +: NUM_SIG];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: captured target, held word, lane index, sample counter and the
  // registered sample/strobe pair.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      // NOTE: the word holding register is reset along with the control path;
      // it is a single register, not a RAM, so the reset costs nothing and
      // keeps write_channel deterministic after reset.
      target_q               <= '0;
      word_q                 <= '0;
      lane_q                 <= '0;
      samples_sent           <= '0;
      write_channel          <= '0;
      write_channel_wrStrobe <= 1'b0;
    end else begin
      // The strobe is a single-cycle pulse; abort has already masked fire.
      write_channel_wrStrobe <= fire;

      if (start_ok) begin
        target_q     <= n_samples_target;
        samples_sent <= '0;
      end

      if (accept) begin
        word_q <= s_data;
        lane_q <= '0;
      end

      if (fire) begin
        // write_channel only changes with a strobe, so it holds otherwise.
        write_channel <= lane_data;
        samples_sent  <= sent_inc;
        lane_q        <= lane_q + LANE_W'(1);
      end
    end
  end

`ifdef APG_FEEDER_OVERRUN_CHECK_EN
  // ---------------------------------------------------------------------------
  // Overrun monitor. The strobe gating should make the first term unreachable;
  // it is kept so a gating fault or a buffer that fills faster than reported
  // still leaves a trace. An accepted start clears the flag, but a violation
  // in that same cycle still sets it.
  // ---------------------------------------------------------------------------
  logic over_now;

  assign over_now = (fire && !room) || (write_buffer_len > DEPTH);

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      overrun <= 1'b0;
    end else if (start_ok) begin
      overrun <= over_now;
    end else if (over_now) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/apg_sample_feeder.md
APG_SAMPLE_FEEDER -- requirements
Module: apg_sample_feeder

Interface
REQ-001 SHALL have parameter NUM_SIG, default 8: sample width in bits; 32/NUM_SIG samples are packed per input word (8 gives 4 lanes).
REQ-002 SHALL have parameter BUF_DEPTH, default 16: downstream buffer occupancy at or above which emission stalls.
REQ-003 SHALL have port axi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axi_resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a transfer.
REQ-006 SHALL have port abort, input, 1 bit: cancels the current transfer.
REQ-007 SHALL have port n_samples_target, input, 32 bits: number of samples to emit, captured on start.
REQ-008 SHALL have port s_data, input, 32 bits: packed sample word.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 SHALL have port s_ready, output, 1 bit: the block accepts s_data.
REQ-011 SHALL have port write_buffer_len, input, 32 bits: current occupancy of the downstream pattern-generator write buffer.
REQ-012 SHALL have port write_channel, output, NUM_SIG bits: sample presented to the pattern generator.
REQ-013 SHALL have port write_channel_wrStrobe, output, 1 bit: one-cycle write strobe for write_channel.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD or EMIT.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port samples_sent, output, 32 bits: count of strobes issued in the current transfer.

Function
REQ-017 SHALL implement the states IDLE, LOAD, EMIT and DONE.
REQ-018 SHALL, in IDLE or DONE, on start: capture n_samples_target, clear samples_sent, and go to LOAD; if the target is 0, go to DONE instead.
REQ-019 SHALL ignore start while in LOAD or EMIT.
REQ-020 SHALL assert s_ready only in LOAD; a word is accepted when s_valid and s_ready are both high, the lane index is set to 0, and the state goes to EMIT.
REQ-021 SHALL, in EMIT, issue a strobe in a cycle only when write_buffer_len < BUF_DEPTH and no strobe was issued in the previous cycle, so the strobe is never high on two consecutive cycles.
REQ-022 SHALL register write_channel and write_channel_wrStrobe together, with write_channel equal to word bits [lane*NUM_SIG +: NUM_SIG], emitting lane 0 first.
REQ-023 SHALL, per strobe, increment samples_sent and the lane index.
REQ-024 SHALL go to DONE when samples_sent reaches the target, discarding any unsent lanes of the current word.
REQ-025 SHALL otherwise return to LOAD after the last lane of a word.
REQ-026 SHALL hold write_channel at its last value when not strobing.
REQ-027 SHALL, when write_buffer_len >= BUF_DEPTH, stall with no strobe and the lane index and state unchanged, for any number of cycles.
REQ-028 SHALL, on abort in any state, go to IDLE next cycle with the strobe low, done low, and samples_sent retained.
REQ-029 SHALL give abort priority over start when both are high in the same cycle.
REQ-030 SHALL hold done until the next accepted start or abort.
REQ-031 SHALL give a strobe latency of 1 cycle from word acceptance, or from the stall releasing, to the strobe.

Reset
REQ-032 SHALL, while axi_resetn is low, asynchronously force state IDLE and s_ready, write_channel_wrStrobe, busy and done to 0.
REQ-033 SHALL, while axi_resetn is low, asynchronously force write_channel, samples_sent, the captured target and the lane index to 0.
REQ-034 SHALL, on reset asserted mid-transfer, drop the transfer with no further strobe and leave the partially emitted word lost.

Configuration
REQ-035 SHALL, with APG_FEEDER_OVERRUN_CHECK_EN defined, add output overrun (1 bit, reset 0), set sticky when a strobe is issued while write_buffer_len >= BUF_DEPTH, or when write_buffer_len exceeds BUF_DEPTH in any cycle.
REQ-036 SHALL, with APG_FEEDER_OVERRUN_CHECK_EN defined, clear overrun only by reset or start.
REQ-037 SHALL, without APG_FEEDER_OVERRUN_CHECK_EN defined, have no overrun port and leave all other behaviour identical.

Verification
REQ-038 SHALL cover: target=4, one word 0x44332211, write_buffer_len=0 -> strobes carry 0x11,0x22,0x33,0x44 on alternate cycles, then done=1 and samples_sent=4.
REQ-039 SHALL cover: target=6, words 0xDDCCBBAA and 0x00FFEE00 -> six strobes AA,BB,CC,DD,00,EE, with byte 0xFF never emitted and done=1.
REQ-040 SHALL cover: write_buffer_len=16 held for 10 cycles in EMIT -> zero strobes; after it drops to 15 -> next lane strobed 1 cycle later.
REQ-041 SHALL cover: target=0 with start -> done=1 next cycle, s_ready never high, no strobe.
REQ-042 SHALL cover: abort after 2 of 4 strobes -> IDLE next cycle, samples_sent=2, done=0, then a new start restarts with samples_sent=0.
REQ-043 SHALL cover: axi_resetn pulsed low mid-EMIT -> all outputs 0 immediately, with no strobe after release until start.
